// File: rtl/ssi_top.sv
// Seven-segment indicator top: debounced hex entry into an 8-digit history,
// shown on a multiplexed common-anode display with unentered digits blanked.
module ssi_top #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REFRESH_DIV     = 16
) (
  input  logic       clk100mhz,
  input  logic       reset,
  input  logic       enter,
  input  logic [3:0] switches,
  output logic [7:0] anodes,
  output logic [7:0] cathodes
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  logic          s1_r;
  logic          s2_r;
  logic          clean_r;
  logic          clean_d_r;
  logic [CW-1:0] cnt_r;
  logic [31:0]   hist_r;
  logic [7:0]    valid_r;
  logic [DW-1:0] div_r;
  logic [2:0]    idx_r;
  logic          push_s;
  logic [3:0]    nib_s;
  logic [7:0]    an_s;
  logic [7:0]    cath_s;

  // Active-high gfedcba pattern for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'h3F;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5B;
      4'h3:    seg7 = 7'h4F;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6D;
      4'h6:    seg7 = 7'h7D;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h6F;
      4'hA:    seg7 = 7'h77;
      4'hB:    seg7 = 7'h7C;
      4'hC:    seg7 = 7'h39;
      4'hD:    seg7 = 7'h5E;
      4'hE:    seg7 = 7'h79;
      4'hF:    seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Two-stage synchronizer for the raw push-button.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= enter;
      s2_r <= s1_r;
    end
  end

  // Debouncer: any agreement with the current level restarts the count.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      clean_r   <= 1'b0;
      clean_d_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
    end else begin
      clean_d_r <= clean_r;
      if (s2_r == clean_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        clean_r <= s2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign push_s = clean_r & ~clean_d_r;

  // History shift: newest nibble lands in digit 0.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      hist_r  <= 32'h0000_0000;
      valid_r <= 8'h00;
    end else if (push_s) begin
      hist_r  <= {hist_r[27:0], switches};
      valid_r <= {valid_r[6:0], 1'b1};
    end else begin
      hist_r  <= hist_r;
      valid_r <= valid_r;
    end
  end

  // Scan divider and digit index.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      div_r <= {DW{1'b0}};
      idx_r <= 3'd0;
    end else if (div_r == DIV_LAST) begin
      div_r <= {DW{1'b0}};
      idx_r <= idx_r + 3'd1;
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // Anode select and segment decode for the digit being scanned.
  always_comb begin
    nib_s  = hist_r[{idx_r, 2'b00} +: 4];
    an_s   = ~(8'b0000_0001 << idx_r);
    cath_s = 8'hFF;
    if (valid_r[idx_r]) begin
      cath_s = {1'b1, ~seg7(nib_s)};
    end else begin
      cath_s = 8'hFF;
    end
  end

  // Anodes and cathodes share one register stage so they always match.
  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      anodes   <= 8'hFF;
      cathodes <= 8'hFF;
    end else begin
      anodes   <= an_s;
      cathodes <= cath_s;
    end
  end

endmodule

// File: tb/tb_ssi_top.sv
// Bench for ssi_top: directed and randomized presses checked against a
// history-queue model of what each digit should show.
module tb_ssi_top;

  localparam int D = 8;
  localparam int R = 16;

  logic       clk100mhz;
  logic       reset;
  logic       enter;
  logic [3:0] switches;
  logic [7:0] anodes;
  logic [7:0] cathodes;

  int tests;
  int fails;
  int ecnt;
  int hist[$];

  // Expected active-low cathodes for each hex value.
  logic [7:0] cath_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  ssi_top #(.DEBOUNCE_CYCLES(D), .REFRESH_DIV(R)) dut (
    .clk100mhz(clk100mhz),
    .reset    (reset),
    .enter    (enter),
    .switches (switches),
    .anodes   (anodes),
    .cathodes (cathodes)
  );

  initial clk100mhz = 1'b0;
  always #5 clk100mhz = ~clk100mhz;

  // Clock edges seen since reset was last released.
  always @(posedge clk100mhz or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic step();
    @(posedge clk100mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_digit(input int i);
    if (i < hist.size()) return cath_tab[hist[hist.size() - 1 - i]];
    return 8'hFF;
  endfunction

  // One full frame: scan position follows from elapsed edges, segments from the model.
  task automatic check_frame(input string tag);
    int d;
    repeat (8 * R) begin
      step();
      d = ((ecnt - 1) / R) % 8;
      check({tag, "_an"}, anodes, ~(8'b0000_0001 << d));
      check({tag, "_cath"}, cathodes, exp_digit(d));
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    enter = lvl;
    repeat (n) step();
  endtask

  // A clean press with the model recording the switch value.
  task automatic press(input logic [3:0] v, input int on_cycles, input int off_cycles);
    switches = v;
    hold(1'b1, on_cycles);
    hist.push_back(int'(v));
    hold(1'b0, off_cycles);
  endtask

  initial begin
    int a, b, g;
    logic [3:0] v;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    enter = 1'b0;
    switches = 4'h0;

    // Reset state
    step();
    step();
    check("reset_an", anodes, 8'hFF);
    check("reset_cath", cathodes, 8'hFF);
    reset = 1'b0;
    step();
    check("first_edge_an", anodes, 8'hFE);
    check("first_edge_cath", cathodes, 8'hFF);
    check_frame("blank");

    // Single and second entry
    press(4'h3, 20, 20);
    check_frame("single");
    press(4'h4, 25, 20);
    check_frame("second");

    // Glitch rejection: D-1 high is ignored, exactly D is accepted
    switches = 4'h9;
    hold(1'b1, 3);
    hold(1'b0, 20);
    hold(1'b1, D - 1);
    hold(1'b0, 20);
    check_frame("glitch");
    switches = 4'hA;
    hold(1'b1, D);
    hist.push_back(10);
    hold(1'b0, 20);
    check_frame("exact_d");

    // Bouncy press yields one entry
    switches = 4'h6;
    repeat (4) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    hold(1'b1, 20);
    hist.push_back(6);
    hold(1'b0, 2);
    hold(1'b1, 2);
    hold(1'b0, 20);
    check_frame("bouncy");

    // Overflow after a fresh reset: 0..8 leaves digits 7..0 = 1..8
    reset = 1'b1;
    step();
    hist.delete();
    reset = 1'b0;
    for (int k = 0; k < 9; k++) press(4'(k), 15, 15);
    check_frame("overflow");

    // Randomized presses with glitches before and inside the hold
    for (int it = 0; it < 24; it++) begin
      v = 4'($urandom_range(0, 15));
      switches = v;
      if ($urandom_range(0, 1) == 1) begin
        hold(1'b1, $urandom_range(1, D - 1));
        hold(1'b0, $urandom_range(2, 5));
      end
      a = $urandom_range(D + 2, 15);
      hold(1'b1, a);
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(1, D - 1);
        hold(1'b0, g);
        b = $urandom_range(2, 10);
        hold(1'b1, b);
      end
      hist.push_back(int'(v));
      hold(1'b0, $urandom_range(D + 4, 20));
      if (it % 4 == 3) check_frame("random");
    end

    // Reset in the middle of a debounce
    switches = 4'h5;
    hold(1'b1, 5);
    #3;
    reset = 1'b1;
    #1;
    check("midreset_an", anodes, 8'hFF);
    check("midreset_cath", cathodes, 8'hFF);
    enter = 1'b0;
    hist.delete();
    step();
    step();
    reset = 1'b0;
    hold(1'b0, 20);
    check_frame("after_midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
